// File: rtl/cobs_uart_rx.sv
// 8N1 UART receiver feeding a COBS frame decoder.
// Output is a byte stream with valid/ready and an end-of-frame flag.
module cobs_uart_rx #(
   parameter int unsigned CountWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [15:0]           prescaler,
   input  logic                  rx_i,
   output logic [7:0]            data_o,
   output logic                  valid_o,
   output logic                  last_o,
   input  logic                  ready_i,
   output logic                  frame_err_o,
   output logic                  overrun_o,
   output logic [CountWidth-1:0] frame_count_o
);

   typedef enum logic [1:0] {
      UIdle,
      UStart,
      UData,
      UStop
   } ustate_e;

   typedef enum logic [1:0] {
      DWait,
      DBlock,
      DResync
   } dstate_e;

   logic sync1_q, sync2_q, prev_q;

   ustate_e     ust_q, ust_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tick, stop_ok, stop_bad;

   logic        rxb_full_q, rxb_full_d;
   logic [7:0]  rxb_q, rxb_d;

   dstate_e     dst_q, dst_d;
   logic [7:0]  rem_q, rem_d;
   logic        za_q, za_d;
   logic        pend_q, pend_d;
   logic        held_v_q, held_v_d;
   logic [7:0]  held_q, held_d;
   logic        out_v_q, out_v_d;
   logic [7:0]  out_q, out_d;
   logic        out_last_q, out_last_d;
   logic [CountWidth-1:0] fc_q, fc_d;

   logic        need_push, out_free, consume;
   logic        push, push_last, dec_err, overrun;
   logic [7:0]  b;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign tick = (cnt_q == 16'd0);

   always_comb begin
      ust_d    = ust_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      unique case (ust_q)
         UIdle: begin
            if (prev_q && !sync2_q) begin
               ust_d = UStart;
               cnt_d = prescaler >> 1;
            end
         end
         UStart: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else if (sync2_q) begin
               ust_d = UIdle;
            end else begin
               ust_d = UData;
               cnt_d = prescaler;
               bit_d = 3'd0;
            end
         end
         UData: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shift_d = {sync2_q, shift_q[7:1]};
               cnt_d   = prescaler;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) ust_d = UStop;
            end
         end
         UStop: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               ust_d    = UIdle;
               stop_ok  = sync2_q;
               stop_bad = !sync2_q;
            end
         end
         default: ust_d = UIdle;
      endcase
   end

   assign b        = rxb_q;
   assign out_free = !out_v_q || ready_i;

   always_comb begin
      need_push = 1'b0;
      unique case (dst_q)
         DWait:   need_push = held_v_q && (b == 8'h00 || pend_q);
         DBlock:  need_push = held_v_q && (b != 8'h00);
         default: need_push = 1'b0;
      endcase
   end

   assign consume = rxb_full_q && (!need_push || out_free);
   assign overrun = stop_ok && rxb_full_q && !consume;

   always_comb begin
      dst_d     = dst_q;
      rem_d     = rem_q;
      za_d      = za_q;
      pend_d    = pend_q;
      held_v_d  = held_v_q;
      held_d    = held_q;
      fc_d      = fc_q;
      push      = 1'b0;
      push_last = 1'b0;
      dec_err   = 1'b0;
      if (consume) begin
         unique case (dst_q)
            DWait: begin
               if (b == 8'h00) begin
                  pend_d = 1'b0;
                  if (held_v_q) begin
                     push      = 1'b1;
                     push_last = 1'b1;
                     held_v_d  = 1'b0;
                     fc_d      = fc_q + CountWidth'(1);
                  end
               end else begin
                  if (pend_q) begin
                     push     = held_v_q;
                     held_d   = 8'h00;
                     held_v_d = 1'b1;
                  end
                  rem_d = b - 8'd1;
                  za_d  = (b != 8'hFF);
                  if (b == 8'd1) begin
                     pend_d = 1'b1;
                  end else begin
                     pend_d = 1'b0;
                     dst_d  = DBlock;
                  end
               end
            end
            DBlock: begin
               if (b == 8'h00) begin
                  dec_err  = 1'b1;
                  held_v_d = 1'b0;
                  pend_d   = 1'b0;
                  dst_d    = DWait;
               end else begin
                  push     = held_v_q;
                  held_d   = b;
                  held_v_d = 1'b1;
                  rem_d    = rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
                     dst_d  = DWait;
                     pend_d = za_q;
                  end
               end
            end
            default: begin
               held_v_d = 1'b0;
               pend_d   = 1'b0;
               if (b == 8'h00) dst_d = DWait;
            end
         endcase
      end
      // Line errors win over whatever the decoder did this cycle.
      if (stop_bad || overrun) begin
         dst_d    = DResync;
         held_v_d = 1'b0;
         pend_d   = 1'b0;
      end
   end

   always_comb begin
      rxb_full_d = rxb_full_q && !consume;
      rxb_d      = rxb_q;
      if (stop_ok && !overrun) begin
         rxb_full_d = 1'b1;
         rxb_d      = shift_q;
      end
   end

   always_comb begin
      out_v_d    = out_v_q;
      out_d      = out_q;
      out_last_d = out_last_q;
      if (push) begin
         out_v_d    = 1'b1;
         out_d      = held_q;
         out_last_d = push_last;
      end else if (ready_i) begin
         out_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ust_q      <= UIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         rxb_full_q <= 1'b0;
         rxb_q      <= '0;
         dst_q      <= DWait;
         rem_q      <= '0;
         za_q       <= 1'b0;
         pend_q     <= 1'b0;
         held_v_q   <= 1'b0;
         held_q     <= '0;
         out_v_q    <= 1'b0;
         out_q      <= '0;
         out_last_q <= 1'b0;
         fc_q       <= '0;
      end else begin
         ust_q      <= ust_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rxb_full_q <= rxb_full_d;
         rxb_q      <= rxb_d;
         dst_q      <= dst_d;
         rem_q      <= rem_d;
         za_q       <= za_d;
         pend_q     <= pend_d;
         held_v_q   <= held_v_d;
         held_q     <= held_d;
         out_v_q    <= out_v_d;
         out_q      <= out_d;
         out_last_q <= out_last_d;
         fc_q       <= fc_d;
      end
   end

   assign data_o        = out_q;
   assign valid_o       = out_v_q;
   assign last_o        = out_last_q;
   assign frame_err_o   = stop_bad || dec_err;
   assign overrun_o     = overrun;
   assign frame_count_o = fc_q;

endmodule

// File: tb/tb_cobs_uart_rx.sv
// Scoreboard bench for cobs_uart_rx: serial stimulus in,
// decoded bytes checked against a queue of expected values.
module tb_cobs_uart_rx;

   localparam int BIT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] prescaler = 16'd15;
   logic        rx = 1'b1;
   logic        ready = 1'b1;
   logic [7:0]  data_o;
   logic        valid_o, last_o, frame_err_o, overrun_o;
   logic [15:0] frame_count_o;

   int checks = 0;
   int errors = 0;
   int ferr_n = 0;
   int ovr_n = 0;
   int exp_cnt = 0;
   logic [8:0] exp_q[$];

   cobs_uart_rx #(.CountWidth(16)) dut (
      .clk_i(clk),
      .reset_ni(rst_n),
      .prescaler(prescaler),
      .rx_i(rx),
      .data_o(data_o),
      .valid_o(valid_o),
      .last_o(last_o),
      .ready_i(ready),
      .frame_err_o(frame_err_o),
      .overrun_o(overrun_o),
      .frame_count_o(frame_count_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err_o) ferr_n++;
         if (overrun_o) ovr_n++;
         if (valid_o && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected got=%h last=%b want=none",
                        data_o, last_o);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if ({last_o, data_o} !== e) begin
                  errors++;
                  $display("FAIL out_byte got=%h last=%b want=%h last=%b",
                           data_o, last_o, e[7:0], e[8]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic expect_b(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
      if (l) exp_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] v, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      if (!stop) repeat (BIT) @(negedge clk);
   endtask

   task automatic send_bytes(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || valid_o) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got=%0d pending want=0",
                  exp_q.size());
      end
   endtask

   initial begin
      int bad, f0, o0;
      repeat (5) @(negedge clk);
      chk("rst_valid", valid_o, 0);
      chk("rst_count", frame_count_o, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (valid_o || frame_err_o || overrun_o || frame_count_o != 0)
            bad++;
      end
      chk("rst_quiet", bad, 0);

      // Basic frame with two implicit zeros
      f0 = ferr_n; o0 = ovr_n;
      expect_b(8'h11, 1'b0);
      expect_b(8'h22, 1'b0);
      expect_b(8'h00, 1'b0);
      expect_b(8'h33, 1'b1);
      send_bytes(64'h0311_2202_3300, 6);
      drain();
      chk("basic_count", frame_count_o, exp_cnt);
      chk("basic_ferr", ferr_n - f0, 0);
      chk("basic_ovr", ovr_n - o0, 0);

      // 0xFF code: 254 literal bytes, no implicit zero
      for (int i = 1; i <= 254; i++) expect_b(8'(i), i == 254);
      send_byte(8'hFF, 1'b1);
      for (int i = 1; i <= 254; i++) send_byte(8'(i), 1'b1);
      send_byte(8'h00, 1'b1);
      drain();
      chk("ff_count", frame_count_o, exp_cnt);
      send_bytes(64'h0100_0000, 4);
      drain();
      chk("empty_count", frame_count_o, exp_cnt);
      chk("empty_ferr", ferr_n - f0, 0);

      // Backpressure forces an overrun
      f0 = ferr_n; o0 = ovr_n;
      ready = 1'b0;
      expect_b(8'h11, 1'b0);
      send_bytes(64'h0311_2202_3300, 6);
      repeat (50) @(negedge clk);
      chk("bp_ovr", ovr_n - o0, 1);
      chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_data", data_o, 8'h11);
      ready = 1'b1;
      drain();
      expect_b(8'h44, 1'b1);
      send_bytes(64'h024400, 3);
      drain();
      chk("bp_count", frame_count_o, exp_cnt);
      chk("bp_ferr", ferr_n - f0, 0);

      // Zero inside a block
      f0 = ferr_n; o0 = ovr_n;
      send_bytes(64'h04AA00, 3);
      repeat (20) @(negedge clk);
      chk("cobs_ferr", ferr_n - f0, 1);
      expect_b(8'h55, 1'b1);
      send_bytes(64'h025500, 3);
      drain();
      chk("cobs_count", frame_count_o, exp_cnt);

      // Bad stop bit then resync on delimiter
      f0 = ferr_n;
      send_bytes(64'h0311, 2);
      send_byte(8'h22, 1'b0);
      send_bytes(64'h3300, 2);
      repeat (20) @(negedge clk);
      chk("stop_ferr", ferr_n - f0, 1);
      chk("stop_ovr", ovr_n - o0, 0);
      expect_b(8'h55, 1'b1);
      send_bytes(64'h025500, 3);
      drain();
      chk("stop_count", frame_count_o, exp_cnt);

      // Reset during data bits of the second byte
      send_byte(8'h03, 1'b1);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_outs",
          {valid_o, last_o, frame_err_o, overrun_o, data_o}, 0);
      chk("mid_rst_count", frame_count_o, 0);
      exp_q.delete();
      exp_cnt = 0;
      rst_n = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      expect_b(8'h66, 1'b1);
      send_bytes(64'h026600, 3);
      drain();
      chk("mid_rst_after", frame_count_o, exp_cnt);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
